// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares the single port of the 32-word data memory between the processor
//   load/store path (port 0) and a test/loader engine (port 1). Arbitration is
//   decided every cycle; a requester may lock the port for consecutive grants,
//   bounded by LOCK_MAX, after which ownership is forcibly released for one
//   contention round. Read data is routed back to the requester that won the
//   read grant, one cycle after that grant.
//
// Handshake (both ports):
//   mN_req is a valid; mN_gnt is the combinational ready/accept. The requester
//   holds req, we, addr, wdata and lock stable until it sees gnt=1 in the same
//   cycle; that cycle is the transfer. A granted read returns mN_rvalid=1 with
//   mN_rdata exactly one cycle later. mN_rdata is 0 whenever mN_rvalid is 0.
//
// Configuration macro:
//   DMEM_ARB_RR_EN  defined   : round-robin contention in IDLE (rr_last).
//                   undefined : port 0 always wins contention in IDLE, except
//                               in the cycle right after a forced release of a
//                               port-0 lock, when port 1 wins.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req/we/lock/addr/wdata  requester N access request (N = 0, 1)
//   mN_gnt                     access accepted this cycle (combinational)
//   mN_rvalid/rdata            read return for requester N
//   mem_read/write/addr/wdata  memory strobes, driven from the winner, 0 idle
//   mem_rdata                  memory read data (registered by the memory)
//   o_dbg_state                FSM state: 0 = IDLE, 1 = LOCK0, 2 = LOCK1
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic [1:0]        o_dbg_state
);

   localparam logic [7:0] LP_LOCK_MAX = 8'(LOCK_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOCK0 = 2'd1,
      S_LOCK1 = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_lock_cnt;
   logic [7:0]        w_lock_cnt_nxt;
   logic [7:0]        w_cnt_inc;
   logic              w_at_max;
   logic              r_rd_pend;
   logic              r_rd_port;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_any;
   logic              w_win;
   logic              w_we;
   logic              w_lock;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

`ifdef DMEM_ARB_RR_EN
   logic              r_rr_last;
`else
   // One-cycle preference for the other port after a forced lock release.
   logic              r_fr_pend;
   logic              r_fr_port;
`endif

   // ---------------------------------------------------------------------------
   // Grant decision. In LOCKk only port k can be granted; the lock owner
   // dropping req for a cycle grants nobody and falls back to IDLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
               w_gnt0 = r_rr_last;
               w_gnt1 = ~r_rr_last;
`else
               w_gnt1 = r_fr_pend & ~r_fr_port;
               w_gnt0 = ~(r_fr_pend & ~r_fr_port);
`endif
            end else begin
               w_gnt0 = m0_req;
               w_gnt1 = m1_req;
            end
         end
         S_LOCK0: w_gnt0 = m0_req;
         S_LOCK1: w_gnt1 = m1_req;
         default: begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
         end
      endcase
   end

   assign w_any   = w_gnt0 | w_gnt1;
   assign w_win   = w_gnt1;
   assign w_we    = w_win ? m1_we    : m0_we;
   assign w_lock  = w_win ? m1_lock  : m0_lock;
   assign w_addr  = w_win ? m1_addr  : m0_addr;
   assign w_wdata = w_win ? m1_wdata : m0_wdata;

   // Count of locked grants including this one: a lock entry from IDLE is
   // grant number 1. Reaching LOCK_MAX with lock still asserted releases.
   assign w_cnt_inc = (r_state == S_IDLE) ? 8'd1 : (r_lock_cnt + 8'd1);
   assign w_at_max  = (w_cnt_inc == LP_LOCK_MAX);

   // ---------------------------------------------------------------------------
   // Next state: a granted cycle with lock held stays/enters LOCK[winner]
   // unless the bound is reached; every other cycle returns to IDLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = S_IDLE;
      w_lock_cnt_nxt = 8'd0;
      if (w_any && w_lock && !w_at_max) begin
         w_state_nxt    = w_win ? S_LOCK1 : S_LOCK0;
         w_lock_cnt_nxt = w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_lock_cnt <= 8'd0;
         r_rd_pend  <= 1'b0;
         r_rd_port  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         r_rr_last  <= 1'b1;
`else
         r_fr_pend  <= 1'b0;
         r_fr_port  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_rd_pend  <= w_any & ~w_we;
         if (w_any) begin
            r_rd_port <= w_win;
         end
`ifdef DMEM_ARB_RR_EN
         if (w_any) begin
            r_rr_last <= w_win;
         end
`else
         r_fr_pend <= w_any & w_lock & w_at_max;
         if (w_any) begin
            r_fr_port <= w_win;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Grants and memory strobes are combinational, so they are masked
   // with rst_n to stay 0 while reset is held even if requests are present.
   // ---------------------------------------------------------------------------
   assign m0_gnt    = w_gnt0 & rst_n;
   assign m1_gnt    = w_gnt1 & rst_n;
   assign mem_read  = w_any & ~w_we & rst_n;
   assign mem_write = w_any &  w_we & rst_n;
   assign mem_addr  = (w_any && rst_n) ? w_addr  : '0;
   assign mem_wdata = (w_any && rst_n) ? w_wdata : '0;

   assign m0_rvalid = r_rd_pend & ~r_rd_port;
   assign m1_rvalid = r_rd_pend &  r_rd_port;
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

   assign o_dbg_state = r_state;

endmodule
